clock_phase_gen: RTL

CLOCK_PHASE_GEN -- requirements
Module: clock_phase_gen

---
 rtl/clock_phase_gen_pkg.sv | 36 +++
 rtl/clock_phase_gen.sv | 77 +++++++
 2 files changed

// File: rtl/clock_phase_gen_pkg.sv
// Shared definitions for the slow-clock phase generator: controller states
// and the mapping from div_sel codes to period geometry.
package clock_phase_gen_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  localparam logic [1:0] DIV_2  = 2'b00;
  localparam logic [1:0] DIV_4  = 2'b01;
  localparam logic [1:0] DIV_8  = 2'b10;
  localparam logic [1:0] DIV_16 = 2'b11;

  // Phase index of the final fast cycle in a slow period (N-1).
  function automatic logic [3:0] last_phase(input logic [1:0] code);
    case (code)
      DIV_2:   return 4'd1;
      DIV_4:   return 4'd3;
      DIV_8:   return 4'd7;
      default: return 4'd15;
    endcase
  endfunction

  // First phase index of the high half of a slow period (N/2).
  function automatic logic [3:0] half_phase(input logic [1:0] code);
    case (code)
      DIV_2:   return 4'd1;
      DIV_4:   return 4'd2;
      DIV_8:   return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/clock_phase_gen.sv
// Divided slow clock with glitch-free halt: proc_clk is decoded from a phase
// counter on clk, and halts only at slow-period boundaries.
module clock_phase_gen
  import clock_phase_gen_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       div_sel,
  input  logic             halt_req,
  output logic             proc_clk,
  output logic             proc_en,
  output logic             halt_ack,
  output logic [3:0]       phase,
  output logic [CNT_W-1:0] slow_cycles
);

  state_t     state, state_nxt;
  logic [1:0] ratio, ratio_nxt;
  logic [3:0] phase_nxt;
  logic       period_end;

  assign period_end = (state != ST_HALTED) && (phase == last_phase(ratio));

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_nxt = state;
    ratio_nxt = ratio;
    phase_nxt = phase;
    case (state)
      ST_HALTED: begin
        ratio_nxt = div_sel;
        phase_nxt = 4'd0;
        if (!halt_req) state_nxt = ST_RUN;
      end
      default: begin
        if (period_end) begin
          phase_nxt = 4'd0;
          ratio_nxt = div_sel;
        end else begin
          phase_nxt = phase + 4'd1;
        end
        if (state == ST_RUN) begin
          if (halt_req) state_nxt = ST_DRAIN;
        end else begin
          if (!halt_req)      state_nxt = ST_RUN;
          else if (period_end) state_nxt = ST_HALTED;
        end
      end
    endcase
  end

  // Outputs are registered from the next-state values so they line up with
  // the phase register without any combinational decode on the ports.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_RUN;
      ratio       <= DIV_2;
      phase       <= 4'd0;
      proc_clk    <= 1'b0;
      proc_en     <= 1'b0;
      halt_ack    <= 1'b0;
      slow_cycles <= '0;
    end else begin
      state    <= state_nxt;
      ratio    <= ratio_nxt;
      phase    <= phase_nxt;
      proc_clk <= (state_nxt != ST_HALTED) && (phase_nxt >= half_phase(ratio_nxt));
      proc_en  <= (state_nxt != ST_HALTED) && (phase_nxt == last_phase(ratio_nxt));
      halt_ack <= (state_nxt == ST_HALTED);
      if (period_end) slow_cycles <= slow_cycles + CNT_W'(1);
    end
  end

endmodule
